// File: rtl/zkey_pulse_emitter.sv
// Key-press waveform generator: emits N active-low pulses with a
// programmable low time and trailing high gap, idle high.
module zkey_pulse_emitter #(
  parameter int unsigned PULSE_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 50000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [3:0] pulse_num,
  output logic       pin_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       rem_q;
  logic             pin_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_zero;
  logic [3:0]       num_eff;

  assign cnt_zero = (cnt_q == '0);
  assign num_eff  = (pulse_num == 4'd0) ? 4'd1 : pulse_num;

  // Outputs are driven straight from flops; no input reaches a pin
  // combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= 4'd0;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rem_q   <= 4'd0;
        pin_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              rem_q   <= num_eff;
              cnt_q   <= P_LOAD;
              state_q <= LOW;
              pin_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          LOW: begin
            if (cnt_zero) begin
              cnt_q   <= G_LOAD;
              rem_q   <= rem_q - 4'd1;
              state_q <= GAP;
              pin_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          GAP: begin
            if (cnt_zero) begin
              if (rem_q != 4'd0) begin
                cnt_q   <= P_LOAD;
                state_q <= LOW;
                pin_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= 4'd0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pin_out = pin_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/zkey_pulse_emitter.md
# zkey_pulse_emitter

Key-press waveform generator: turns a single-cycle start request into one or more active-low pulses on an output pin with programmable low time and inter-pulse gap. It is the transmitting counterpart of the key edge-detection path. It drives test stimulus into key/trigger inputs and external active-low strobes in the SinglePhotonCounter design. Its idle level and pulse polarity match what the key edge detector expects: idle high, falling edge = press.

## Interface
- PULSE_CYCLES, default 50000: cycles pin_out is held low per pulse; legal range ≥1 and < 2^CNT_W.
- GAP_CYCLES, default 50000: cycles pin_out is held high after each pulse; legal range ≥1 and < 2^CNT_W.
- CNT_W, default 16: width of the phase counter.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; low forces idle.
- start  input  1  single-cycle request; sampled only in IDLE.
- pulse_num  input  4  number of pulses per request, latched at start; 0 is treated as 1.
- pin_out  output  1  generated waveform, registered; idle high, active low.
- busy  output  1  high while a pulse sequence is in progress.
- done  output  1  single-cycle strobe at sequence completion.

## Operation
- Reset values: pin_out=1, busy=0, done=0, state=IDLE, counters=0.
- FSM states: IDLE, LOW, GAP.
- **IDLE**
  - pin_out=1, busy=0.
  - On `start & en`: latch remaining = (pulse_num==0 ? 1 : pulse_num), load phase counter with PULSE_CYCLES-1, and go to LOW.
- **LOW**
  - pin_out=0, busy=1.
  - The counter decrements each cycle. At 0: load GAP_CYCLES-1, decrement remaining, and go to GAP.
- **GAP**
  - pin_out=1, busy=1.
  - The counter decrements each cycle. At 0:
    - if remaining ≠ 0, load PULSE_CYCLES-1 and go to LOW;
    - else go to IDLE and assert done for one cycle.
- The trailing gap is always emitted, so a downstream 2-flop edge detector sees a settled high before done.
- start while busy (LOW or GAP) is ignored; it is not queued.
- start in the same cycle done is high is accepted, because the FSM is already in IDLE.
- **en low in any state** (checked before all other transitions)
  - The next cycle gives pin_out=1, busy=0, state IDLE.
  - done is not asserted. Counters are cleared.
  - A partially emitted low pulse is truncated.
- start with en low is ignored.
- pulse_num changes after start do not affect the running sequence.
- Asynchronous reset mid-sequence immediately returns all outputs to their reset values.

## Timing
- start sampled high at rising edge T (IDLE, en=1):
  - cycles T+1 … T+P: pin_out=0;
  - cycles T+P+1 … T+P+G: pin_out=1.
  - Here P=PULSE_CYCLES and G=GAP_CYCLES.
- Pulse k (1-based) falls at T+1+(k-1)(P+G).
- busy=1 for cycles T+1 … T+N(P+G).
- done=1 in cycle T+N(P+G)+1 only; busy=0 in that cycle.
- Total request-to-done latency is N(P+G)+1 cycles.
- All outputs are registered, so no combinational path exists from inputs to outputs.
- Latency from en deassertion to idle outputs is 1 cycle.

## Test plan
Sim parameters: P=4, G=3, CNT_W=4.
- **Reset:** rst_n low with clock running → pin_out=1, busy=0, done=0. Release rst_n and leave start low for 20 cycles → outputs unchanged.
- **Single pulse:** start at T with pulse_num=1 → pin_out=0 at T+1..T+4 and 1 at T+5..T+7; busy high T+1..T+7; done high only at T+8.
- **Three pulses, pulse_num=3:** pin_out falls at T+1, T+8, T+15 and each low lasts 4 cycles; done at T+22; exactly 3 falling and 3 rising edges are counted by a 2-flop edge detector on pin_out.
- **pulse_num=0:** the waveform is identical to the pulse_num=1 case.
- **Re-trigger:**
  - start pulses at T+2 and T+6 during a running sequence → ignored, done still at T+8.
  - start at T+8, the done cycle → new pulse falls at T+9.
- **Abort:** with pulse_num=2, drop en at T+3 → pin_out=1 and busy=0 from T+4, with no done. Raise en and start again → a normal sequence follows.
- **Async reset mid-LOW:** assert rst_n low at T+2 (between clock edges) → pin_out returns to 1 and busy to 0 immediately.
